redirect_ctrl: RTL and testbench

Pipeline redirect and flush sequencer between the fetch stage and the execute stage. It detects EX-stage branch mispredictions, using predict-not-taken, so a misprediction is `ex_pc + 4 != ex_pcn`. It arbitrates them against ID-stage exceptions and load-use hazards, and drives per-stage flush/stall signals. It also holds a redirect request to fetch until fetch accepts it, and for traps it first drains older instructions and then redirects to the trap vector while latching EPC and cause.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/redirect_ctrl_if.sv | 74 +++++++
 rtl/exc_prio_enc.sv | 28 ++
 rtl/redirect_ctrl.sv | 161 ++++++++++++++++
 tb/tb_redirect_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the
// redirect/flush sequencer.
package pipeline_pkg;

   localparam int DATA_WIDTH  = 64;
   localparam int EXC_WIDTH   = 8;
   localparam int CAUSE_WIDTH = 3;

   localparam int EXC_FETCH  = 0;
   localparam int EXC_DECODE = 1;

   typedef logic [DATA_WIDTH-1:0] addr_t;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      REDIRECT
   } redirect_state_e;

endpackage

// File: rtl/redirect_ctrl_if.sv
// Redirect/flush bundle between the pipeline
// stages and the redirect sequencer.
interface redirect_ctrl_if
   import pipeline_pkg::*;
();

   logic                   ex_valid;
   addr_t                  ex_pc;
   addr_t                  ex_pcn;
   logic                   id_valid;
   addr_t                  id_pc;
   logic [EXC_WIDTH-1:0]   id_exception;
   logic                   load_use;
   addr_t                  trap_vector;
   logic                   redirect_ready;
   logic                   redirect_valid;
   addr_t                  redirect_pc;
   logic                   flush_if;
   logic                   flush_id;
   logic                   flush_ex;
   logic                   stall_if;
   logic                   stall_id;
   addr_t                  epc;
   logic [CAUSE_WIDTH-1:0] cause;
   logic                   trap_taken;
   logic                   busy;

   modport master (
      input  ex_valid,
      input  ex_pc,
      input  ex_pcn,
      input  id_valid,
      input  id_pc,
      input  id_exception,
      input  load_use,
      input  trap_vector,
      input  redirect_ready,
      output redirect_valid,
      output redirect_pc,
      output flush_if,
      output flush_id,
      output flush_ex,
      output stall_if,
      output stall_id,
      output epc,
      output cause,
      output trap_taken,
      output busy
   );

   modport slave (
      output ex_valid,
      output ex_pc,
      output ex_pcn,
      output id_valid,
      output id_pc,
      output id_exception,
      output load_use,
      output trap_vector,
      output redirect_ready,
      input  redirect_valid,
      input  redirect_pc,
      input  flush_if,
      input  flush_id,
      input  flush_ex,
      input  stall_if,
      input  stall_id,
      input  epc,
      input  cause,
      input  trap_taken,
      input  busy
   );

endinterface

// File: rtl/exc_prio_enc.sv
// Lowest-set-bit encoder for exception flags;
// bit 0 is the highest priority cause.
module exc_prio_enc
   import pipeline_pkg::*;
(
   input  logic [EXC_WIDTH-1:0]   req,
   output logic [CAUSE_WIDTH-1:0] idx,
   output logic                   any
);

   always_comb begin
      idx = '0;
      priority case (1'b1)
         req[0]:  idx = 3'd0;
         req[1]:  idx = 3'd1;
         req[2]:  idx = 3'd2;
         req[3]:  idx = 3'd3;
         req[4]:  idx = 3'd4;
         req[5]:  idx = 3'd5;
         req[6]:  idx = 3'd6;
         req[7]:  idx = 3'd7;
         default: idx = '0;
      endcase
   end

   assign any = |req;

endmodule

// File: rtl/redirect_ctrl.sv
// Redirect and flush sequencer: mispredict and
// trap arbitration, trap drain, held redirect.
module redirect_ctrl
   import pipeline_pkg::*;
#(
   parameter int FetchError   = EXC_FETCH,
   parameter int DecodeError  = EXC_DECODE,
   parameter int DRAIN_CYCLES = 3
) (
   input logic             clk,
   input logic             rst_n,
   redirect_ctrl_if.master rif
);

   localparam int CW = $clog2(DRAIN_CYCLES + 1);

   if (DRAIN_CYCLES < 1 ||
       FetchError < 0 || FetchError >= EXC_WIDTH ||
       DecodeError < 0 || DecodeError >= EXC_WIDTH ||
       FetchError == DecodeError) begin : g_bad_param
      $error("redirect_ctrl: illegal parameters");
   end

   redirect_state_e        state, state_n;
   logic [CW-1:0]          cnt, cnt_n;
   logic                   trap_flag;
   logic                   mis, exc;
   logic [CAUSE_WIDTH-1:0] enc_idx;
   logic                   enc_any;

   logic take_mis, take_exc, take_vec;
   logic abort, accept;
   logic fl_if, fl_id, fl_ex, st_if, st_id;

   addr_t                  rpc_q, epc_q, epc_sh;
   logic [CAUSE_WIDTH-1:0] cause_q, cause_sh;
   logic                   rv_q, tt_q, busy_q;

   exc_prio_enc u_enc (
      .req (rif.id_exception),
      .idx (enc_idx),
      .any (enc_any)
   );

   // Predict-not-taken: any next PC other than pc+4 is a miss.
   assign mis = rif.ex_valid &
                (rif.ex_pc + addr_t'(4) != rif.ex_pcn);
   assign exc = rif.id_valid & enc_any;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_n;
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      take_mis = 1'b0;
      take_exc = 1'b0;
      take_vec = 1'b0;
      abort    = 1'b0;
      accept   = 1'b0;
      fl_if    = 1'b0;
      fl_id    = 1'b0;
      fl_ex    = 1'b0;
      st_if    = 1'b0;
      st_id    = 1'b0;
      unique case (state)
         RUN: begin
            if (mis) begin
               fl_if    = 1'b1;
               fl_id    = 1'b1;
               take_mis = 1'b1;
               state_n  = REDIRECT;
            end else if (exc) begin
               fl_if    = 1'b1;
               fl_id    = 1'b1;
               take_exc = 1'b1;
               cnt_n    = CW'(DRAIN_CYCLES);
               state_n  = DRAIN;
            end else if (rif.load_use) begin
               st_if = 1'b1;
               st_id = 1'b1;
               fl_ex = 1'b1;
            end
         end
         DRAIN: begin
            st_if = 1'b1;
            fl_id = 1'b1;
            // An older instruction mispredicted: the trap was wrong-path.
            if (mis) begin
               take_mis = 1'b1;
               abort    = 1'b1;
               cnt_n    = '0;
               state_n  = REDIRECT;
            end else if (cnt == CW'(1)) begin
               take_vec = 1'b1;
               cnt_n    = '0;
               state_n  = REDIRECT;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         REDIRECT: begin
            fl_if = 1'b1;
            if (rif.redirect_ready) begin
               accept  = 1'b1;
               state_n = RUN;
            end
         end
         default: state_n = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         trap_flag <= 1'b0;
         rpc_q     <= '0;
         epc_q     <= '0;
         epc_sh    <= '0;
         cause_q   <= '0;
         cause_sh  <= '0;
         rv_q      <= 1'b0;
         tt_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         cnt    <= cnt_n;
         rv_q   <= (state_n == REDIRECT);
         busy_q <= (state_n != RUN);
         tt_q   <= accept & trap_flag;
         if (take_mis) rpc_q <= rif.ex_pcn;
         if (take_vec) rpc_q <= rif.trap_vector;
         if (take_vec)             trap_flag <= 1'b1;
         else if (abort || accept) trap_flag <= 1'b0;
         if (take_exc) begin
            epc_sh   <= epc_q;
            cause_sh <= cause_q;
            epc_q    <= rif.id_pc;
            cause_q  <= enc_idx;
         end
         if (abort) begin
            epc_q   <= epc_sh;
            cause_q <= cause_sh;
         end
      end
   end

   assign rif.flush_if       = fl_if;
   assign rif.flush_id       = fl_id;
   assign rif.flush_ex       = fl_ex;
   assign rif.stall_if       = st_if;
   assign rif.stall_id       = st_id;
   assign rif.redirect_valid = rv_q;
   assign rif.redirect_pc    = rpc_q;
   assign rif.epc            = epc_q;
   assign rif.cause          = cause_q;
   assign rif.trap_taken     = tt_q;
   assign rif.busy           = busy_q;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed vector bench for redirect_ctrl.
// Rows hold one cycle of stimulus and expected outputs.
module tb_redirect_ctrl;
   import pipeline_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   redirect_ctrl_if rif ();

   redirect_ctrl #(
      .DRAIN_CYCLES (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rif   (rif)
   );

   int checks = 0;
   int failures = 0;

   // fl = {flush_if, flush_id, flush_ex, stall_if, stall_id}
   typedef struct {
      logic       exv;
      addr_t      expc;
      addr_t      expcn;
      logic       idv;
      addr_t      idpc;
      logic [7:0] idexc;
      logic       lu;
      logic       rdy;
      logic [4:0] fl;
      logic       rv;
      addr_t      rpc;
      logic       busy;
      logic       tt;
      addr_t      epc;
      logic [2:0] cause;
   } vec_t;

   vec_t tbl[19];

   function automatic vec_t mk(
      logic exv, addr_t expc, addr_t expcn,
      logic idv, addr_t idpc, logic [7:0] idexc,
      logic lu, logic rdy, logic [4:0] fl,
      logic rv, addr_t rpc, logic busy, logic tt,
      addr_t epc, logic [2:0] cause);
      vec_t v;
      v.exv = exv;   v.expc = expc; v.expcn = expcn;
      v.idv = idv;   v.idpc = idpc; v.idexc = idexc;
      v.lu = lu;     v.rdy = rdy;   v.fl = fl;
      v.rv = rv;     v.rpc = rpc;   v.busy = busy;
      v.tt = tt;     v.epc = epc;   v.cause = cause;
      return v;
   endfunction

   task automatic chk(string name, logic [63:0] act,
                      logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic drive_idle();
      rif.ex_valid       = 1'b0;
      rif.ex_pc          = '0;
      rif.ex_pcn         = '0;
      rif.id_valid       = 1'b0;
      rif.id_pc          = '0;
      rif.id_exception   = '0;
      rif.load_use       = 1'b0;
      rif.redirect_ready = 1'b0;
      rif.trap_vector    = 64'h800;
   endtask

   task automatic check_outs(string tag, vec_t v);
      chk($sformatf("%s.flush_if", tag), rif.flush_if, v.fl[4]);
      chk($sformatf("%s.flush_id", tag), rif.flush_id, v.fl[3]);
      chk($sformatf("%s.flush_ex", tag), rif.flush_ex, v.fl[2]);
      chk($sformatf("%s.stall_if", tag), rif.stall_if, v.fl[1]);
      chk($sformatf("%s.stall_id", tag), rif.stall_id, v.fl[0]);
      chk($sformatf("%s.rvalid", tag), rif.redirect_valid, v.rv);
      chk($sformatf("%s.rpc", tag), rif.redirect_pc, v.rpc);
      chk($sformatf("%s.busy", tag), rif.busy, v.busy);
      chk($sformatf("%s.trap_taken", tag), rif.trap_taken, v.tt);
      chk($sformatf("%s.epc", tag), rif.epc, v.epc);
      chk($sformatf("%s.cause", tag), rif.cause, v.cause);
   endtask

   task automatic run_vec(string tag, vec_t v);
      @(negedge clk);
      rif.ex_valid       = v.exv;
      rif.ex_pc          = v.expc;
      rif.ex_pcn         = v.expcn;
      rif.id_valid       = v.idv;
      rif.id_pc          = v.idpc;
      rif.id_exception   = v.idexc;
      rif.load_use       = v.lu;
      rif.redirect_ready = v.rdy;
      #1;
      check_outs(tag, v);
   endtask

   localparam addr_t WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

   initial begin
      drive_idle();
      // idle, mispredict held 3 cycles unaccepted, load-use
      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000,
                   0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 'h100, 'h200, 0, 0, 0, 0, 0, 5'b11000,
                   0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b10000,
                   1, 'h200, 1, 0, 0, 0);
      tbl[3]  = mk(0, 0, 0, 1, 'h55, 'h01, 1, 0, 5'b10000,
                   1, 'h200, 1, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b10000,
                   1, 'h200, 1, 0, 0, 0);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b10000,
                   1, 'h200, 1, 0, 0, 0);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000,
                   0, 'h200, 0, 0, 0, 0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00111,
                   0, 'h200, 0, 0, 0, 0);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00111,
                   0, 'h200, 0, 0, 0, 0);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000,
                   0, 'h200, 0, 0, 0, 0);
      // load-use with mispredict: flush wins, no stall
      tbl[10] = mk(1, 'h400, 'h480, 0, 0, 0, 1, 0, 5'b11000,
                   0, 'h200, 0, 0, 0, 0);
      tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b10000,
                   1, 'h480, 1, 0, 0, 0);
      // wrap-around and invalid EX are not mispredicts
      tbl[12] = mk(1, WRAP_PC, 0, 0, 0, 0, 0, 0, 5'b00000,
                   0, 'h480, 0, 0, 0, 0);
      tbl[13] = mk(0, 'h10, 'h90, 0, 0, 0, 0, 0, 5'b00000,
                   0, 'h480, 0, 0, 0, 0);
      // mispredict with coincident ID exception
      tbl[14] = mk(1, 'h500, 'h600, 1, 'h44, 'h02, 0, 0,
                   5'b11000, 0, 'h480, 0, 0, 0, 0);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b10000,
                   1, 'h600, 1, 0, 0, 0);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b10000,
                   1, 'h600, 1, 0, 0, 0);
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000,
                   0, 'h600, 0, 0, 0, 0);
      tbl[18] = mk(1, 'h700, 'h704, 0, 0, 0, 0, 0, 5'b00000,
                   0, 'h600, 0, 0, 0, 0);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++)
         run_vec($sformatf("row%0d", i), tbl[i]);

      // trap: 0x0C -> cause 2, three DRAIN cycles
      run_vec("trap.n", mk(0, 0, 0, 1, 'h40, 'h0C, 0, 0,
              5'b11000, 0, 'h600, 0, 0, 0, 0));
      for (int i = 1; i <= 3; i++)
         run_vec($sformatf("trap.drain%0d", i),
                 mk(0, 0, 0, 1, 'h99, 'h01, 1, 0, 5'b01010,
                    0, 'h600, 1, 0, 'h40, 2));
      run_vec("trap.wait", mk(0, 0, 0, 0, 0, 0, 0, 0,
              5'b10000, 1, 'h800, 1, 0, 'h40, 2));
      run_vec("trap.acc", mk(0, 0, 0, 0, 0, 0, 0, 1,
              5'b10000, 1, 'h800, 1, 0, 'h40, 2));
      run_vec("trap.pulse", mk(0, 0, 0, 0, 0, 0, 0, 0,
              5'b00000, 0, 'h800, 0, 1, 'h40, 2));
      run_vec("trap.after", mk(0, 0, 0, 0, 0, 0, 0, 0,
              5'b00000, 0, 'h800, 0, 0, 'h40, 2));

      // abort: mispredict in 2nd DRAIN cycle reverts epc/cause
      run_vec("abort.n", mk(0, 0, 0, 1, 'h60, 'h80, 0, 0,
              5'b11000, 0, 'h800, 0, 0, 'h40, 2));
      run_vec("abort.d1", mk(0, 0, 0, 0, 0, 0, 0, 0,
              5'b01010, 0, 'h800, 1, 0, 'h60, 7));
      run_vec("abort.d2", mk(1, 'h200, 'h300, 0, 0, 0, 0, 0,
              5'b01010, 0, 'h800, 1, 0, 'h60, 7));
      run_vec("abort.rdr", mk(0, 0, 0, 0, 0, 0, 0, 1,
              5'b10000, 1, 'h300, 1, 0, 'h40, 2));
      run_vec("abort.run", mk(0, 0, 0, 0, 0, 0, 0, 0,
              5'b00000, 0, 'h300, 0, 0, 'h40, 2));
      run_vec("abort.after", mk(0, 0, 0, 0, 0, 0, 0, 0,
              5'b00000, 0, 'h300, 0, 0, 'h40, 2));

      // asynchronous reset in the middle of REDIRECT
      run_vec("rst.mis", mk(1, 'h100, 'h900, 0, 0, 0, 0, 0,
              5'b11000, 0, 'h300, 0, 0, 'h40, 2));
      run_vec("rst.rdr", mk(0, 0, 0, 0, 0, 0, 0, 0,
              5'b10000, 1, 'h900, 1, 0, 'h40, 2));
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("rst.async", mk(0, 0, 0, 0, 0, 0, 0, 0,
                 5'b00000, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      run_vec("rst.idle", mk(0, 0, 0, 0, 0, 0, 0, 0,
              5'b00000, 0, 0, 0, 0, 0, 0));
      run_vec("rst.lu", mk(0, 0, 0, 0, 0, 0, 1, 0,
              5'b00111, 0, 0, 0, 0, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
